// File: rtl/mips_fetch_pkg.sv
// ============================================================================
//  mips_fetch_pkg
//  Shared fetch-stage types and constants.
//  Rev 1.0
// ============================================================================
`default_nettype none

package mips_fetch_pkg;

   typedef enum logic [0:0] {
      ST_RUN = 1'b0,
      ST_ERR = 1'b1
   } fetch_state_e;

   localparam logic [31:0] c_pc_inc           = 32'd4;
   localparam logic [31:0] c_default_reset_pc = 32'd0;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
//  fetch_queue
//  Synchronous FIFO of DEPTH entries (power of two) with flush.
//  Rev 1.0
// ============================================================================
`default_nettype none

module fetch_queue #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_aw:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   // A pop frees a slot in the same edge, so a full queue can still accept a push.
   assign w_do_push = i_push & (~o_full | i_pop);
   assign w_do_pop  = i_pop & ~o_empty;

   assign o_full  = (r_count == (c_aw+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_rdata = r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + c_aw'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_aw'(1);
         end
         r_count <= r_count + (c_aw+1)'(w_do_push) - (c_aw+1)'(w_do_pop);
      end
   end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
// ============================================================================
//  instr_fetch_ctrl
//  PC sequencing and prefetch queue for the instruction fetch stage.
//  Optional misaligned-redirect trap: define FETCH_MISALIGN_TRAP_EN.
//  Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch_ctrl
   import mips_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = c_default_reset_pc,
   parameter int          QDEPTH   = 2
)(
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        misalign_err
);

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;
   logic [31:0]  r_pc;
   logic [31:0]  w_pc_nxt;
   logic [31:0]  w_redirect_target;
   logic         w_misaligned;
   logic         w_push;
   logic         w_pop;
   logic         w_full;
   logic         w_empty;
   logic [63:0]  w_head;

   assign imem_addr  = r_pc;
   assign inst_valid = ~w_empty;
   assign inst_pc    = w_head[63:32];
   assign inst_data  = w_head[31:0];

   // Redirect flushes the queue, so any pop or push in that cycle is dropped.
   assign w_pop  = inst_valid & inst_ready & ~redirect_valid;
   assign w_push = (r_state == ST_RUN) & ~halt & ~redirect_valid & (~w_full | w_pop);

`ifdef FETCH_MISALIGN_TRAP_EN
   assign w_misaligned      = |redirect_pc[1:0];
   assign w_redirect_target = redirect_pc;
   assign misalign_err      = (r_state == ST_ERR);
`else
   assign w_misaligned      = 1'b0;
   assign w_redirect_target = redirect_pc & ~32'd3;
   assign misalign_err      = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      if (redirect_valid) begin
         w_pc_nxt = w_redirect_target;
         if (w_misaligned) begin
            w_state_nxt = ST_ERR;
         end
      end else if (w_push) begin
         w_pc_nxt = r_pc + c_pc_inc;
      end
   end

   fetch_queue #(
      .DEPTH (QDEPTH),
      .WIDTH (64)
   ) u_queue (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .i_wdata ({r_pc, imem_data}),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
// ============================================================================
//  tb_instr_fetch_ctrl
//  Directed scoreboard bench for instr_fetch_ctrl (default and wrap-around PC).
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, rst2_n;
   logic [31:0] imem_addr, imem_data, inst_data, inst_pc, redirect_pc;
   logic        inst_valid, inst_ready, redirect_valid, halt, misalign_err;
   logic [31:0] imem_addr2, imem_data2, inst_data2, inst_pc2;
   logic        inst_valid2, misalign_err2;

   int n_pass = 0;
   int n_tot  = 0;
   logic [31:0] sb [$];

   always #5 clk = ~clk;

   function automatic logic [31:0] imem_model(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
   endfunction

   assign imem_data  = imem_model(imem_addr);
   assign imem_data2 = imem_model(imem_addr2);

   instr_fetch_ctrl dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
      .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
      .inst_ready(inst_ready), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .halt(halt), .misalign_err(misalign_err)
   );

   instr_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
      .clk(clk), .rst_n(rst2_n), .imem_addr(imem_addr2), .imem_data(imem_data2),
      .inst_valid(inst_valid2), .inst_data(inst_data2), .inst_pc(inst_pc2),
      .inst_ready(1'b1), .redirect_valid(1'b0), .redirect_pc(32'd0),
      .halt(1'b0), .misalign_err(misalign_err2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Compare the queue head against the scoreboard; retire it if it will be consumed.
   task automatic chk_head(input string tag);
      chk({tag, ".valid"}, {31'd0, inst_valid}, 32'd1);
      if (sb.size() == 0) begin
         n_tot++;
         $error("FAIL %s.sb: observed empty scoreboard expected an entry", tag);
      end else begin
         chk({tag, ".pc"}, inst_pc, sb[0]);
         chk({tag, ".data"}, inst_data, imem_model(sb[0]));
         if (inst_ready && !redirect_valid) void'(sb.pop_front());
      end
   endtask

   task automatic step_head(input string tag);
      cyc();
      chk_head(tag);
   endtask

   initial begin
      rst_n = 1'b0; rst2_n = 1'b0;
      inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; halt = 1'b0;
      #2;
      chk("rst.valid", {31'd0, inst_valid}, 32'd0);
      chk("rst.pc", inst_pc, 32'd0);
      chk("rst.data", inst_data, 32'd0);
      chk("rst.addr", imem_addr, 32'd0);
      chk("rst.err", {31'd0, misalign_err}, 32'd0);
      chk("rstw.pc", inst_pc2, 32'd0);

      // Reset release, streaming consumer
      cyc();
      rst_n = 1'b1;
      chk("rel.valid", {31'd0, inst_valid}, 32'd0);
      sb.push_back(32'd0); sb.push_back(32'd4); sb.push_back(32'd8); sb.push_back(32'd12);
      for (int i = 0; i < 4; i++) step_head("stream");

      // Asynchronous reset mid-transfer
      rst_n = 1'b0;
      #1;
      chk("arst.valid", {31'd0, inst_valid}, 32'd0);
      chk("arst.addr", imem_addr, 32'd0);
      chk("arst.pc", inst_pc, 32'd0);

      // Stalled consumer fills the queue
      inst_ready = 1'b0;
      rst_n = 1'b1;
      sb.delete();
      sb.push_back(32'd0); sb.push_back(32'd4);
      for (int i = 0; i < 10; i++) step_head("stall");
      chk("stall.addr", imem_addr, 32'd8);

      // Redirect while full, with a pop attempt that must be dropped
      inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd8;
      cyc();
      redirect_valid = 1'b0;
      chk("redir.valid", {31'd0, inst_valid}, 32'd0);
      sb.delete();
      sb.push_back(32'd8); sb.push_back(32'd12); sb.push_back(32'd16);
      for (int i = 0; i < 3; i++) step_head("redir");

      // Halt drains the queue, then a redirect under halt
      halt = 1'b1;
      cyc();
      chk("halt.drain", {31'd0, inst_valid}, 32'd0);
      chk("halt.addr", imem_addr, 32'd20);
      redirect_valid = 1'b1; redirect_pc = 32'h20;
      cyc();
      redirect_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("hredir.valid", {31'd0, inst_valid}, 32'd0);
         chk("hredir.addr", imem_addr, 32'h20);
         cyc();
      end
      chk("hredir.valid", {31'd0, inst_valid}, 32'd0);
      halt = 1'b0;
      sb.delete();
      sb.push_back(32'h20); sb.push_back(32'h24);
      for (int i = 0; i < 2; i++) step_head("resume");

      // Misaligned redirect
      redirect_valid = 1'b1; redirect_pc = 32'h6;
      cyc();
      redirect_valid = 1'b0;
      chk("mis.valid", {31'd0, inst_valid}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
      for (int i = 0; i < 3; i++) begin
         chk("mis.err", {31'd0, misalign_err}, 32'd1);
         cyc();
         chk("mis.valid", {31'd0, inst_valid}, 32'd0);
      end
`else
      chk("mis.err", {31'd0, misalign_err}, 32'd0);
      chk("mis.addr", imem_addr, 32'h4);
      sb.delete();
      sb.push_back(32'h4); sb.push_back(32'h8);
      for (int i = 0; i < 2; i++) step_head("mis");
`endif

      // Wrap-around PC on the second instance
      rst2_n = 1'b1;
      chk("wrap.rel", {31'd0, inst_valid2}, 32'd0);
      cyc();
      chk("wrap.v0", {31'd0, inst_valid2}, 32'd1);
      chk("wrap.pc0", inst_pc2, 32'hFFFF_FFF8);
      chk("wrap.d0", inst_data2, imem_model(32'hFFFF_FFF8));
      cyc();
      chk("wrap.pc1", inst_pc2, 32'hFFFF_FFFC);
      cyc();
      chk("wrap.pc2", inst_pc2, 32'h0000_0000);
      chk("wrap.d2", inst_data2, imem_model(32'h0));

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0, PC loaded at reset (word-aligned).
REQ-002 SHALL have parameter QDEPTH, default 2, prefetch queue entries (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_addr  output  32  byte address driven to the instruction memory sel input.
REQ-006 SHALL have port imem_data  input  32  instruction memory out, combinational, valid in the same cycle.
REQ-007 SHALL have port inst_valid  output  1  queue head holds a valid instruction.
REQ-008 SHALL have port inst_data  output  32  instruction word at queue head.
REQ-009 SHALL have port inst_pc  output  32  byte address of inst_data.
REQ-010 SHALL have port inst_ready  input  1  consumer accepts head when high with inst_valid.
REQ-011 SHALL have port redirect_valid  input  1  branch/jump redirect request, single-cycle.
REQ-012 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-013 SHALL have port halt  input  1  suspend fetching while high.
REQ-014 SHALL have port misalign_err  output  1  sticky misaligned-target flag.

Function
REQ-015 SHALL drive imem_addr = PC register combinationally every cycle.
REQ-016 SHALL push {PC, imem_data} and set PC <= PC+4 at an edge when state is RUN, halt=0, redirect_valid=0, and the queue is not full or is popped in that cycle.
REQ-017 SHALL pop the head at an edge when inst_valid=1 and inst_ready=1; head outputs are registered, with no empty-queue bypass.
REQ-018 SHALL produce fetch-to-output latency of 1 cycle: instruction at imem_addr in cycle N is presented on inst_valid in cycle N+1 at the earliest.
REQ-019 SHALL, on redirect_valid=1 in cycle N, flush all queue entries and discard any pop or push, load PC <= redirect_pc, and drive inst_valid=0 in cycle N+1 with inst_pc=redirect_pc visible in cycle N+2.
REQ-020 SHALL give redirect priority over halt, pop and push; a redirect while halt=1 flushes and loads PC, and fetching stays suspended.
REQ-021 SHALL keep draining the queue while halt=1; it SHALL resume pushing the first edge after halt falls.
REQ-022 SHALL hold inst_data/inst_pc stable while inst_valid=1 and inst_ready=0.
REQ-023 SHALL wrap the PC modulo 2^32 (32'hFFFFFFFC+4 = 0).
REQ-024 SHALL implement states RUN and ERR: RUN->ERR only per REQ-028; ERR exits only on reset.

Reset
REQ-025 SHALL, on rst_n=0 and at any time including mid-transfer, asynchronously set PC=RESET_PC, empty the queue, inst_valid=0, inst_data=0, inst_pc=0, misalign_err=0, and state=RUN.
REQ-026 SHALL begin fetching at the first rising edge after rst_n rises.

Configuration
REQ-027 SHALL use macro FETCH_MISALIGN_TRAP_EN.
REQ-028 SHALL, with the macro defined, on a redirect with redirect_pc[1:0]!=0, flush the queue, set misalign_err=1 and state=ERR the next cycle, and push nothing more.
REQ-029 SHALL, without the macro, force PC[1:0]=2'b00 on redirect (target truncated to a word boundary), tie misalign_err to 0, and never enter ERR.

Structure
REQ-030 SHALL take the state enum, PC increment constant (4) and default reset PC from shared package mips_fetch_pkg.
REQ-031 SHALL instantiate one sub-module fetch_queue: a parameterised synchronous FIFO of QDEPTH entries x 64 bits with push, pop, flush, full and empty.

Verification
REQ-032 SHALL check reset release with inst_ready=1 -> inst_pc 0,4,8,12 on consecutive cycles, first inst_valid one cycle after the first fetch edge.
REQ-033 SHALL check inst_ready=0 for 10 cycles -> queue fills at QDEPTH=2, imem_addr holds 8, and the head stays inst_pc=0 with stable data.
REQ-034 SHALL check redirect to 8 while the queue is full -> inst_valid=0 next cycle, then inst_pc=8, and no flushed entry is ever presented.
REQ-035 SHALL check halt=1 with redirect to 32'h20 -> queue empties, imem_addr=32'h20 and no pushes; halt falls -> inst_pc=32'h20 presented next.
REQ-036 SHALL check redirect to 32'h6 -> with macro: misalign_err=1 and inst_valid stays 0; without macro: next inst_pc=32'h4.
REQ-037 SHALL check RESET_PC=32'hFFFFFFF8 -> inst_pc FFFFFFF8, FFFFFFFC, 00000000.
